wb_regfile_buffered: RTL and testbench

Parametrised write-back stage and register file for the multi-cycle MIPS core. It accepts write-back requests from the memory stage under a valid/ready handshake. Each request selects its destination (rt or rd field) and is queued in a small write buffer that drains into the register array one entry per cycle. Two read ports see buffered writes through bypass, and a registered done pulse returns the pipeline token to fetch.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_write_buffer.sv | 125 ++++++++++++
 rtl/wb_regfile_buffered.sv | 136 +++++++++++++
 tb/tb_wb_regfile_buffered.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back stage / register file slice.
//   DEST_RT / DEST_RD : encodings of the reg_dest destination select
//   WB_DATA_W / WB_ADDR_W : default register width and register address width
//   wb_entry_t : one pending register write (address + data) at default widths
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic DEST_RT = 1'b0;
    localparam logic DEST_RD = 1'b1;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_buffer.sv
// -----------------------------------------------------------------------------
// wb_write_buffer
// Circular queue of pending register writes. The queue drains one entry per
// pop into the register array. Two lookup ports return the youngest queued
// write whose address matches, so reads can bypass uncommitted data.
//   clock, reset         : rising-edge clock, async active-high reset
//   push/push_addr/data  : enqueue one entry (ignored when full)
//   pop                  : dequeue the head entry (ignored when empty)
//   count                : occupied entries (registered)
//   head_addr/head_data  : oldest entry, valid when count != 0
//   look_addr_x          : lookup address for port A / B
//   look_hit_x/data_x    : youngest matching entry for port A / B
// -----------------------------------------------------------------------------
module wb_write_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int BUF_DEPTH = 2,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] look_addr_a,
    output logic              look_hit_a,
    output logic [DATA_W-1:0] look_data_a,
    input  logic [ADDR_W-1:0] look_addr_b,
    output logic              look_hit_b,
    output logic [DATA_W-1:0] look_data_b
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SUM_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            entries_r [BUF_DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;

    // Modulo-BUF_DEPTH pointer offset; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + SUM_W'(off);
        if (sum >= SUM_W'(BUF_DEPTH)) begin
            sum = sum - SUM_W'(BUF_DEPTH);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    assign push_s = push && (count_r < CNT_W'(BUF_DEPTH));
    assign pop_s  = pop && (count_r != {CNT_W{1'b0}});

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entries_r[i] <= '{addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else begin
            if (push_s) begin
                entries_r[tail_r] <= '{addr: push_addr, data: push_data};
                tail_r            <= wrap_idx(tail_r, 1);
            end
            if (pop_s) begin
                head_r <= wrap_idx(head_r, 1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Youngest-match lookup: walk oldest to youngest so later hits override.
    always_comb begin
        look_hit_a  = 1'b0;
        look_data_a = {DATA_W{1'b0}};
        look_hit_b  = 1'b0;
        look_data_b = {DATA_W{1'b0}};
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if ((CNT_W'(i) < count_r) &&
                (entries_r[wrap_idx(head_r, i)].addr == look_addr_a)) begin
                look_hit_a  = 1'b1;
                look_data_a = entries_r[wrap_idx(head_r, i)].data;
            end else begin
                look_hit_a  = look_hit_a;
                look_data_a = look_data_a;
            end
            if ((CNT_W'(i) < count_r) &&
                (entries_r[wrap_idx(head_r, i)].addr == look_addr_b)) begin
                look_hit_b  = 1'b1;
                look_data_b = entries_r[wrap_idx(head_r, i)].data;
            end else begin
                look_hit_b  = look_hit_b;
                look_data_b = look_data_b;
            end
        end
    end

    assign count     = count_r;
    assign head_addr = entries_r[head_r].addr;
    assign head_data = entries_r[head_r].data;

endmodule

// File: rtl/wb_regfile_buffered.sv
// -----------------------------------------------------------------------------
// wb_regfile_buffered
// Write-back stage and register file of the multi-cycle MIPS core. Requests
// from the memory stage are accepted under valid/ready, routed to rt or rd,
// queued in a small write buffer and drained into the array one per cycle.
// Read ports bypass queued writes; wb_done returns the token to fetch.
//   clock, reset             : rising-edge clock, async active-high reset
//   wb_valid / wb_ready      : request handshake (ready = buffer not full)
//   reg_write, reg_dest      : write enable, destination select (0=rt, 1=rd)
//   addr_rt, addr_rd, wb_data: destination fields and write value
//   wb_done                  : one-cycle pulse after every accepted request
//   rd_addr_x / rd_data_x    : combinational read ports A and B
//   buf_count                : occupied write-buffer entries
// -----------------------------------------------------------------------------
module wb_regfile_buffered
    import wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int BUF_DEPTH = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wb_valid,
    output logic                           wb_ready,
    input  logic                           reg_write,
    input  logic                           reg_dest,
    input  logic [ADDR_W-1:0]              addr_rt,
    input  logic [ADDR_W-1:0]              addr_rd,
    input  logic [DATA_W-1:0]              wb_data,
    output logic                           wb_done,
    input  logic [ADDR_W-1:0]              rd_addr_a,
    output logic [DATA_W-1:0]              rd_data_a,
    input  logic [ADDR_W-1:0]              rd_addr_b,
    output logic [DATA_W-1:0]              rd_data_b,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic              wb_done_r;
    logic [CNT_W-1:0]  count_s;
    logic              ready_s;
    logic              accept_s;
    logic [ADDR_W-1:0] dest_s;
    logic              zero_dest_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              hit_a_s;
    logic [DATA_W-1:0] bypass_a_s;
    logic              hit_b_s;
    logic [DATA_W-1:0] bypass_b_s;

    assign ready_s     = (count_s < CNT_W'(BUF_DEPTH));
    assign accept_s    = wb_valid && ready_s;
    assign dest_s      = (reg_dest == DEST_RD) ? addr_rd : addr_rt;
    assign zero_dest_s = (ZERO_REG != 0) && (dest_s == {ADDR_W{1'b0}});
    // Requests without a write, or aimed at the hardwired zero register,
    // are still accepted and still return the token; they just never queue.
    assign push_s      = accept_s && reg_write && !zero_dest_s;
    assign pop_s       = (count_s != {CNT_W{1'b0}});

    wb_write_buffer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .push_addr  (dest_s),
        .push_data  (wb_data),
        .pop        (pop_s),
        .count      (count_s),
        .head_addr  (head_addr_s),
        .head_data  (head_data_s),
        .look_addr_a(rd_addr_a),
        .look_hit_a (hit_a_s),
        .look_data_a(bypass_a_s),
        .look_addr_b(rd_addr_b),
        .look_hit_b (hit_b_s),
        .look_data_b(bypass_b_s)
    );

    // Register array: commits the buffer head every cycle the buffer is non-empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (pop_s) begin
            regs_r[head_addr_s] <= head_data_s;
        end else begin
            regs_r[head_addr_s] <= regs_r[head_addr_s];
        end
    end

    // Done token: one pulse the cycle after each accepted request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_done_r <= 1'b0;
        end else begin
            wb_done_r <= accept_s;
        end
    end

    // Read priority: zero register, then youngest buffered write, then array.
    always_comb begin
        rd_data_a = regs_r[rd_addr_a];
        rd_data_b = regs_r[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_a == {ADDR_W{1'b0}})) begin
            rd_data_a = {DATA_W{1'b0}};
        end else if (hit_a_s) begin
            rd_data_a = bypass_a_s;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
        if ((ZERO_REG != 0) && (rd_addr_b == {ADDR_W{1'b0}})) begin
            rd_data_b = {DATA_W{1'b0}};
        end else if (hit_b_s) begin
            rd_data_b = bypass_b_s;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

    assign wb_ready  = ready_s;
    assign wb_done   = wb_done_r;
    assign buf_count = count_s;

endmodule

// File: tb/tb_wb_regfile_buffered.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_buffered
// Directed bench: one instance with the default two-entry buffer and one with
// a single-entry buffer, sharing clock and reset. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile_buffered;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // Default instance (BUF_DEPTH = 2)
    logic        wb_valid  = 1'b0;
    logic        wb_ready;
    logic        reg_write = 1'b0;
    logic        reg_dest  = 1'b0;
    logic [4:0]  addr_rt   = 5'd0;
    logic [4:0]  addr_rd   = 5'd0;
    logic [31:0] wb_data   = 32'd0;
    logic        wb_done;
    logic [4:0]  rd_addr_a = 5'd0;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b = 5'd0;
    logic [31:0] rd_data_b;
    logic [1:0]  buf_count;

    // Single-entry instance (BUF_DEPTH = 1)
    logic        wb_valid1  = 1'b0;
    logic        wb_ready1;
    logic        reg_write1 = 1'b0;
    logic        reg_dest1  = 1'b0;
    logic [4:0]  addr_rt1   = 5'd0;
    logic [4:0]  addr_rd1   = 5'd0;
    logic [31:0] wb_data1   = 32'd0;
    logic        wb_done1;
    logic [4:0]  rd_addr_a1 = 5'd0;
    logic [31:0] rd_data_a1;
    logic [4:0]  rd_addr_b1 = 5'd0;
    logic [31:0] rd_data_b1;
    logic [0:0]  buf_count1;

    int n_vec = 0;
    int n_err = 0;
    int done_pulses = 0;

    always #5 clock = ~clock;

    wb_regfile_buffered dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .reg_write(reg_write), .reg_dest(reg_dest),
        .addr_rt(addr_rt), .addr_rd(addr_rd), .wb_data(wb_data),
        .wb_done(wb_done),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .buf_count(buf_count)
    );

    wb_regfile_buffered #(.BUF_DEPTH(1)) dut1 (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid1), .wb_ready(wb_ready1),
        .reg_write(reg_write1), .reg_dest(reg_dest1),
        .addr_rt(addr_rt1), .addr_rd(addr_rd1), .wb_data(wb_data1),
        .wb_done(wb_done1),
        .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
        .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1),
        .buf_count(buf_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", {31'd0, wb_ready}, 32'd1);
        chk("rst_count", {30'd0, buf_count}, 32'd0);
        chk("rst_done", {31'd0, wb_done}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk("rst_rd_a", rd_data_a, 32'd0);
            chk("rst_rd_b", rd_data_b, 32'd0);
        end

        // ---------------- rd destination, bypass then array ----------------
        wb_valid = 1'b1; reg_write = 1'b1; reg_dest = 1'b1;
        addr_rd = 5'd7; addr_rt = 5'd2; wb_data = 32'hDEADBEEF;
        rd_addr_a = 5'd7; rd_addr_b = 5'd2;
        #1;
        chk("no_bypass_incoming", rd_data_a, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("bypass_r7", rd_data_a, 32'hDEADBEEF);
        chk("rt_not_written", rd_data_b, 32'd0);
        chk("done_pulse1", {31'd0, wb_done}, 32'd1);
        chk("count_one", {30'd0, buf_count}, 32'd1);
        tick();
        chk("count_drained", {30'd0, buf_count}, 32'd0);
        chk("done_low", {31'd0, wb_done}, 32'd0);
        chk("array_r7", rd_data_a, 32'hDEADBEEF);

        // ---------------- rt destination ----------------
        wb_valid = 1'b1; reg_dest = 1'b0;
        addr_rt = 5'd3; addr_rd = 5'd9; wb_data = 32'h12;
        tick();
        wb_valid = 1'b0;
        tick();
        rd_addr_a = 5'd3; rd_addr_b = 5'd9;
        #1;
        chk("array_r3", rd_data_a, 32'h12);
        chk("r9_untouched", rd_data_b, 32'd0);

        // ---------------- write to register 0 is dropped ----------------
        wb_valid = 1'b1; addr_rt = 5'd0; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0;
        rd_addr_a = 5'd0;
        #1;
        chk("r0_count", {30'd0, buf_count}, 32'd0);
        chk("r0_done", {31'd0, wb_done}, 32'd1);
        chk("r0_read", rd_data_a, 32'd0);
        tick();

        // ---------------- reg_write=0: token only ----------------
        wb_valid = 1'b1; reg_write = 1'b0; addr_rt = 5'd4; wb_data = 32'h77;
        tick();
        wb_valid = 1'b0; reg_write = 1'b1;
        rd_addr_a = 5'd4;
        #1;
        chk("nowr_done", {31'd0, wb_done}, 32'd1);
        chk("nowr_count", {30'd0, buf_count}, 32'd0);
        tick();
        chk("nowr_r4", rd_data_a, 32'd0);

        // ---------------- back-to-back writes to reg 5 ----------------
        wb_valid = 1'b1; addr_rt = 5'd5; wb_data = 32'h1;
        rd_addr_a = 5'd5;
        tick();
        chk("b2b_first", rd_data_a, 32'h1);
        chk("b2b_ready", {31'd0, wb_ready}, 32'd1);
        wb_data = 32'h2;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("b2b_youngest", rd_data_a, 32'h2);
        chk("b2b_count", {30'd0, buf_count}, 32'd1);
        chk("b2b_done", {31'd0, wb_done}, 32'd1);
        tick();
        chk("b2b_drained", {30'd0, buf_count}, 32'd0);
        chk("b2b_final", rd_data_a, 32'h2);
        chk("b2b_done_low", {31'd0, wb_done}, 32'd0);

        // ---------------- single-entry buffer, valid held ----------------
        // Accepts on edges 0, 2, 4; ready is low after each accept.
        reg_write1 = 1'b1; reg_dest1 = 1'b0; wb_valid1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            addr_rt1 = 5'(10 + k / 2);
            wb_data1 = 32'h100 + 32'(k / 2);
            #1;
            chk("d1_ready_pre", {31'd0, wb_ready1}, (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            if (wb_done1) done_pulses++;
            chk("d1_done", {31'd0, wb_done1}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("d1_count", {31'd0, buf_count1}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        wb_valid1 = 1'b0;
        tick();
        if (wb_done1) done_pulses++;
        chk("d1_pulses", 32'(done_pulses), 32'd3);
        for (int r = 0; r < 4; r++) begin
            rd_addr_a1 = 5'(10 + r);
            #1;
            chk("d1_reg", rd_data_a1, (r < 3) ? (32'h100 + 32'(r)) : 32'd0);
        end

        // ---------------- reset mid-drain ----------------
        wb_valid = 1'b1; addr_rt = 5'd20; wb_data = 32'hA;
        tick();
        addr_rt = 5'd21; wb_data = 32'hB;
        tick();
        wb_valid = 1'b0;
        rd_addr_a = 5'd20; rd_addr_b = 5'd21;
        #1;
        chk("pre_rst_r21", rd_data_b, 32'hB);
        chk("pre_rst_count", {30'd0, buf_count}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_r20", rd_data_a, 32'd0);
        chk("mid_rst_r21", rd_data_b, 32'd0);
        chk("mid_rst_count", {30'd0, buf_count}, 32'd0);
        chk("mid_rst_done", {31'd0, wb_done}, 32'd0);
        rd_addr_a = 5'd7; rd_addr_b = 5'd5;
        #1;
        chk("mid_rst_r7", rd_data_a, 32'd0);
        chk("mid_rst_r5", rd_data_b, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
